// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises fetch (imem) and load/store (dmem)
// requests onto one physical memory port; every output is registered.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  imem_read,
  input  logic [DATA_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [DATA_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [MASK_WIDTH-1:0] dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [DATA_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [MASK_WIDTH-1:0] pmem_byte_enable,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;

  state_e                  state_q;
  logic                    last_grant_d_q;
  logic                    pmem_read_q;
  logic                    pmem_write_q;
  logic [DATA_WIDTH-1:0]   pmem_address_q;
  logic [DATA_WIDTH-1:0]   pmem_wdata_q;
  logic [MASK_WIDTH-1:0]   pmem_byte_enable_q;
  logic [DATA_WIDTH-1:0]   imem_rdata_q;
  logic [DATA_WIDTH-1:0]   dmem_rdata_q;
  logic                    imem_resp_q;
  logic                    dmem_resp_q;

  logic dmem_req;
  logic grant_i_d;
  logic grant_d_d;

  // On a tie the side that did not win last time is served.
  assign dmem_req  = dmem_read | dmem_write;
  assign grant_i_d = imem_read & (~dmem_req | last_grant_d_q);
  assign grant_d_d = dmem_req & ~grant_i_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      last_grant_d_q     <= 1'b1;
      pmem_read_q        <= 1'b0;
      pmem_write_q       <= 1'b0;
      pmem_address_q     <= '0;
      pmem_wdata_q       <= '0;
      pmem_byte_enable_q <= '0;
      imem_rdata_q       <= '0;
      dmem_rdata_q       <= '0;
      imem_resp_q        <= 1'b0;
      dmem_resp_q        <= 1'b0;
    end else begin
      imem_resp_q <= 1'b0;
      dmem_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_i_d) begin
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= imem_address;
            last_grant_d_q <= 1'b0;
            state_q        <= BUSY_I;
          end else if (grant_d_d) begin
            // A simultaneous read and write collapses to the write alone.
            pmem_read_q        <= dmem_read & ~dmem_write;
            pmem_write_q       <= dmem_write;
            pmem_address_q     <= dmem_address;
            pmem_wdata_q       <= dmem_wdata;
            pmem_byte_enable_q <= dmem_byte_enable;
            last_grant_d_q     <= 1'b1;
            state_q            <= BUSY_D;
          end
        end
        BUSY_I: begin
          if (pmem_resp) begin
            imem_rdata_q <= pmem_rdata;
            imem_resp_q  <= 1'b1;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= RESP_I;
          end
        end
        BUSY_D: begin
          if (pmem_resp) begin
            if (pmem_read_q) begin
              dmem_rdata_q <= pmem_rdata;
            end
            dmem_resp_q  <= 1'b1;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= RESP_D;
          end
        end
        RESP_I, RESP_D: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign pmem_byte_enable = pmem_byte_enable_q;
  assign imem_rdata       = imem_rdata_q;
  assign dmem_rdata       = dmem_rdata_q;
  assign imem_resp        = imem_resp_q;
  assign dmem_resp        = dmem_resp_q;

  // Only one requester is ever answered, and only one strobe is ever high.
  a_one_resp: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem_resp_q && dmem_resp_q));
  a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
    !(pmem_read_q && pmem_write_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven request vectors with a
// scoreboard of expected physical transactions and responses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_read = 1'b0;
  logic [15:0] imem_address = '0;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [15:0] dmem_address = '0;
  logic [15:0] dmem_wdata = '0;
  logic [1:0]  dmem_byte_enable = '0;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  mem_arbiter #(.DATA_WIDTH(16), .MASK_WIDTH(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_read        (imem_read),
    .imem_address     (imem_address),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          iCount;
    int          dCount;
    logic        dRead;
    logic        dWrite;
    logic [15:0] iAddr;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic [1:0]  dMask;
    int          waits;
  } vec_t;

  typedef struct {
    logic        isRead;
    logic        isWrite;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    int          len;
    bit          checkData;
  } pmem_exp_t;

  typedef struct {
    bit          isD;
    logic [15:0] rdata;
  } resp_exp_t;

  pmem_exp_t pmemQ[$];
  resp_exp_t respQ[$];

  int compared = 0;
  int mismatched = 0;

  bit          memAuto = 1'b1;
  int          memWait = 0;
  int          waitCnt = 0;
  bit          modelLastD = 1'b1;
  logic [15:0] lastDR = '0;

  function automatic logic [15:0] memData(input logic [15:0] a);
    return a ^ 16'h1274;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers after memWait extra cycles of strobe.
  always @(negedge clk) begin
    if (memAuto) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        waitCnt   = 0;
      end else if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
        if (waitCnt == memWait) begin
          pmem_resp  = 1'b1;
          pmem_rdata = memData(pmem_address);
        end else begin
          waitCnt++;
        end
      end
    end
  end

  // Scoreboard monitor for physical strobes and requester responses.
  bit        inTxn = 1'b0;
  int        txnLen = 0;
  pmem_exp_t cur;
  resp_exp_t r;

  always @(negedge clk) begin
    if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
      if (!inTxn) begin
        if (pmemQ.size() == 0) begin
          checkOutput("unexpected pmem strobe", 32'd1, 32'd0);
        end else begin
          cur    = pmemQ.pop_front();
          inTxn  = 1'b1;
          txnLen = 0;
        end
      end
      if (inTxn) begin
        txnLen++;
        checkOutput("pmem_read", {31'd0, pmem_read}, {31'd0, cur.isRead});
        checkOutput("pmem_write", {31'd0, pmem_write}, {31'd0, cur.isWrite});
        checkOutput("pmem_address", {16'd0, pmem_address}, {16'd0, cur.addr});
        if (cur.checkData) begin
          checkOutput("pmem_wdata", {16'd0, pmem_wdata}, {16'd0, cur.wdata});
          checkOutput("pmem_byte_enable", {30'd0, pmem_byte_enable}, {30'd0, cur.mask});
        end
      end
    end else if (inTxn) begin
      inTxn = 1'b0;
      checkOutput("strobe length", txnLen, cur.len);
    end

    if (imem_resp === 1'b1 && dmem_resp === 1'b1) begin
      checkOutput("both resp at once", 32'd1, 32'd0);
    end else if (imem_resp === 1'b1 || dmem_resp === 1'b1) begin
      if (respQ.size() == 0) begin
        checkOutput("unexpected resp", 32'd1, 32'd0);
      end else begin
        r = respQ.pop_front();
        checkOutput("resp side is dmem", {31'd0, dmem_resp}, {31'd0, r.isD});
        if (r.isD) checkOutput("dmem_rdata", {16'd0, dmem_rdata}, {16'd0, r.rdata});
        else       checkOutput("imem_rdata", {16'd0, imem_rdata}, {16'd0, r.rdata});
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int iRem, dRem, n, total;
    iRem  = v.iCount;
    dRem  = v.dCount;
    total = v.iCount + v.dCount;
    // Transaction-level expectation: tie goes to the side not served last.
    while (iRem > 0 || dRem > 0) begin
      bit pickD;
      pickD = (dRem > 0) && (iRem == 0 || !modelLastD);
      if (pickD) begin
        pmemQ.push_back('{isRead: v.dRead & ~v.dWrite, isWrite: v.dWrite, addr: v.dAddr,
                          wdata: v.dWdata, mask: v.dMask, len: v.waits + 1, checkData: 1'b1});
        if (!v.dWrite) lastDR = memData(v.dAddr);
        respQ.push_back('{isD: 1'b1, rdata: lastDR});
        dRem--;
      end else begin
        pmemQ.push_back('{isRead: 1'b1, isWrite: 1'b0, addr: v.iAddr, wdata: 16'h0,
                          mask: 2'b00, len: v.waits + 1, checkData: 1'b0});
        respQ.push_back('{isD: 1'b0, rdata: memData(v.iAddr)});
        iRem--;
      end
      modelLastD = pickD;
    end

    memWait = v.waits;
    @(negedge clk);
    imem_read        = (v.iCount > 0);
    imem_address     = v.iAddr;
    dmem_read        = (v.dCount > 0) & v.dRead;
    dmem_write       = (v.dCount > 0) & v.dWrite;
    dmem_address     = v.dAddr;
    dmem_wdata       = v.dWdata;
    dmem_byte_enable = v.dMask;
    iRem = v.iCount;
    dRem = v.dCount;
    n    = 0;
    while ((iRem > 0 || dRem > 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (imem_resp === 1'b1 && iRem > 0) begin
        iRem--;
        if (iRem == 0) imem_read = 1'b0;
      end
      if (dmem_resp === 1'b1 && dRem > 0) begin
        dRem--;
        if (dRem == 0) begin
          dmem_read  = 1'b0;
          dmem_write = 1'b0;
        end
      end
    end
    if (iRem > 0 || dRem > 0) begin
      checkOutput("vector timeout", 32'd1, 32'd0);
      imem_read  = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
    end else begin
      checkOutput("cycles to last resp", n, 3 * total - 1 + total * v.waits);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " pmem_read"}, {31'd0, pmem_read}, 32'd0);
    checkOutput({tag, " pmem_write"}, {31'd0, pmem_write}, 32'd0);
    checkOutput({tag, " pmem_address"}, {16'd0, pmem_address}, 32'd0);
    checkOutput({tag, " pmem_wdata"}, {16'd0, pmem_wdata}, 32'd0);
    checkOutput({tag, " pmem_byte_enable"}, {30'd0, pmem_byte_enable}, 32'd0);
    checkOutput({tag, " imem_resp"}, {31'd0, imem_resp}, 32'd0);
    checkOutput({tag, " dmem_resp"}, {31'd0, dmem_resp}, 32'd0);
    checkOutput({tag, " imem_rdata"}, {16'd0, imem_rdata}, 32'd0);
    checkOutput({tag, " dmem_rdata"}, {16'd0, dmem_rdata}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{iCount:1, dCount:0, dRead:0, dWrite:0, iAddr:16'h0040, dAddr:16'h0000, dWdata:16'h0000, dMask:2'b00, waits:0};
    vecs[1] = '{iCount:0, dCount:1, dRead:0, dWrite:1, iAddr:16'h0000, dAddr:16'h8002, dWdata:16'hBEEF, dMask:2'b10, waits:3};
    vecs[2] = '{iCount:0, dCount:1, dRead:1, dWrite:0, iAddr:16'h0000, dAddr:16'h0100, dWdata:16'h0000, dMask:2'b00, waits:1};
    vecs[3] = '{iCount:0, dCount:1, dRead:0, dWrite:1, iAddr:16'h0000, dAddr:16'h0102, dWdata:16'hCAFE, dMask:2'b11, waits:0};
    vecs[4] = '{iCount:1, dCount:1, dRead:1, dWrite:0, iAddr:16'h0200, dAddr:16'h0300, dWdata:16'h0000, dMask:2'b00, waits:0};
    vecs[5] = '{iCount:1, dCount:0, dRead:0, dWrite:0, iAddr:16'h0A0A, dAddr:16'h0000, dWdata:16'h0000, dMask:2'b00, waits:2};
    vecs[6] = '{iCount:1, dCount:1, dRead:1, dWrite:0, iAddr:16'h0220, dAddr:16'h0330, dWdata:16'h0000, dMask:2'b00, waits:0};
    vecs[7] = '{iCount:0, dCount:1, dRead:1, dWrite:1, iAddr:16'h0000, dAddr:16'h0404, dWdata:16'h5555, dMask:2'b01, waits:1};
    vecs[8] = '{iCount:2, dCount:2, dRead:1, dWrite:0, iAddr:16'h0600, dAddr:16'h0700, dWdata:16'h0000, dMask:2'b00, waits:0};

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset lands while a store is on the physical port; the late pmem_resp must be ignored.
    memAuto = 1'b0;
    pmemQ.push_back('{isRead: 1'b0, isWrite: 1'b1, addr: 16'h9000, wdata: 16'h1111,
                      mask: 2'b11, len: 1, checkData: 1'b1});
    @(negedge clk);
    dmem_write       = 1'b1;
    dmem_address     = 16'h9000;
    dmem_wdata       = 16'h1111;
    dmem_byte_enable = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pmem_write === 1'b1) break;
    end
    checkOutput("busy store strobe", {31'd0, pmem_write}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    checkAllZero("mid-busy reset");
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hDEAD;
    dmem_write = 1'b0;
    reset_n    = 1'b1;
    @(negedge clk);
    checkOutput("late pmem_resp dmem_resp", {31'd0, dmem_resp}, 32'd0);
    checkOutput("late pmem_resp pmem_read", {31'd0, pmem_read}, 32'd0);
    checkOutput("late pmem_resp dmem_rdata", {16'd0, dmem_rdata}, 32'd0);
    pmem_resp  = 1'b0;
    waitCnt    = 0;
    memAuto    = 1'b1;
    modelLastD = 1'b1;
    lastDR     = '0;

    // Both held after reset: grants must run I, D, I.
    applyStimulus('{iCount:2, dCount:1, dRead:1, dWrite:0, iAddr:16'h0040, dAddr:16'h0500,
                    dWdata:16'h0000, dMask:2'b00, waits:0});
    applyStimulus('{iCount:1, dCount:0, dRead:0, dWrite:0, iAddr:16'h0042, dAddr:16'h0000,
                    dWdata:16'h0000, dMask:2'b00, waits:1});

    repeat (3) @(negedge clk);
    checkOutput("pending resp expectations", respQ.size(), 32'd0);
    checkOutput("pending pmem expectations", pmemQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Responder for the CPU's split instruction/data memory interface. It accepts requests from the fetch side (`imem_*`) and the load/store side (`dmem_*`), and funnels them one at a time onto a single physical memory port (`pmem_*`). It returns read data and a one-cycle `*_resp` pulse to the requester that was served. It sits between `cpu_datapath` and the memory model or cache. Arbitration is round-robin when both sides request in the same cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of address, read data and write data (lc3b_word)
- `MASK_WIDTH`, 2, byte-enable width (lc3b_mem_wmask)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `imem_read`  in  1  fetch read request, held until `imem_resp`
- `imem_address`  in  DATA_WIDTH  fetch address
- `imem_rdata`  out  DATA_WIDTH  fetch read data, valid while `imem_resp`=1
- `imem_resp`  out  1  one-cycle completion pulse to fetch
- `dmem_read`  in  1  data read request, held until `dmem_resp`
- `dmem_write`  in  1  data write request, held until `dmem_resp`
- `dmem_address`  in  DATA_WIDTH  data address
- `dmem_wdata`  in  DATA_WIDTH  store data
- `dmem_byte_enable`  in  MASK_WIDTH  store byte mask
- `dmem_rdata`  out  DATA_WIDTH  load data, valid while `dmem_resp`=1
- `dmem_resp`  out  1  one-cycle completion pulse to data side
- `pmem_read`  out  1  physical read strobe
- `pmem_write`  out  1  physical write strobe
- `pmem_address`  out  DATA_WIDTH  physical address
- `pmem_wdata`  out  DATA_WIDTH  physical write data
- `pmem_byte_enable`  out  MASK_WIDTH  physical byte mask
- `pmem_rdata`  in  DATA_WIDTH  physical read data, valid with `pmem_resp`
- `pmem_resp`  in  1  physical completion, may arrive any cycle while a strobe is high

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. Internal flag `last_grant` (I/D).
- IDLE: sample `imem_read` and `dmem_req` = `dmem_read | dmem_write`.
  - Only one side requesting: grant that side.
  - Both requesting: grant the side opposite `last_grant`.
  - On grant, latch address, wdata and mask into the `pmem_*` registers; set `last_grant`; go to BUSY_I or BUSY_D.
- BUSY_I: `pmem_read`=1, `pmem_write`=0.
- BUSY_D: `pmem_write`=`dmem_write`, `pmem_read`=`dmem_read & ~dmem_write`, both as latched. A write takes precedence if both were asserted; the read is dropped and no rdata is captured.
- In BUSY_x, `pmem_resp`=1 causes:
  - a read captures `pmem_rdata` into `x_rdata`;
  - state goes to RESP_x;
  - strobes drop at the same edge.
- RESP_x: `x_resp`=1 for exactly this cycle, then return to IDLE. The requester drops or changes its request at the edge that ends RESP_x. IDLE therefore never re-serves a completed request.
- `imem_rdata`/`dmem_rdata` hold their last captured value between responses. A write response leaves `dmem_rdata` unchanged.
- Requests arriving while not in IDLE are not acknowledged. They stay pending because requesters hold them.
- `pmem_address`, `pmem_wdata` and `pmem_byte_enable` stay stable throughout BUSY_x.
- Reset values: state IDLE, `last_grant`=D (the first tie goes to I), all outputs 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Zero-wait memory (`pmem_resp` in the first BUSY cycle):
  - cycle 0: request sampled;
  - cycle 1: strobe high;
  - cycle 2: `x_resp`.
  - A requester holding a request sees one transaction every 3 cycles.
- N wait cycles add N cycles to the BUSY phase.
- Reset mid-operation: the next edge forces IDLE, strobes deassert, no `*_resp` is issued, and a late `pmem_resp` arriving in IDLE is ignored.
- `pmem_resp` outside BUSY_x is ignored.
- Tie fairness: with both sides continuously requesting, grants alternate I, D, I, D. Neither side waits more than one foreign transaction.

## Test plan
- Fetch only, zero-wait: `imem_read`=1, addr 0x0040, pmem returns 0x1234 → `pmem_read` in cycle 1 with address 0x0040; `imem_resp`=1 and `imem_rdata`=0x1234 in cycle 2; `dmem_resp` stays 0.
- Store with 3 wait states: `dmem_write`=1, addr 0x8002, data 0xBEEF, mask 2'b10 → `pmem_write` held with those values for 4 cycles; `dmem_resp` 1 cycle after `pmem_resp`; `dmem_rdata` unchanged.
- Simultaneous requests after reset, both held → grant order I, D, I; the next request is accepted in the cycle after each `*_resp`; no response is duplicated.
- `dmem_read` and `dmem_write` both asserted → only `pmem_write` asserts; `dmem_resp` pulses once.
- Reset asserted during BUSY_D with `pmem_resp` arriving one cycle later → all outputs 0, IDLE, no `dmem_resp`; a fetch issued after reset release completes normally.
